// File: rtl/delimiter_pkg.sv
// Shared constants, field-geometry helpers and parameter validation for the
// axis_delimiter slice.
package delimiter_pkg;

  localparam int unsigned MAX_OUTPUTS = 8;

  typedef logic [MAX_OUTPUTS-1:0][31:0] widths_t;

  localparam logic [0:0] SLOT_IDLE = 1'b0;
  localparam logic [0:0] SLOT_HELD = 1'b1;

  function automatic int unsigned field_off(widths_t widths, int unsigned n);
    int unsigned off = 0;
    for (int unsigned i = 0; i < MAX_OUTPUTS; i++) begin
      if (i < n) off += widths[i[2:0]];
    end
    return off;
  endfunction

  // Entries from the last field onward are zeroed so field_w can recognise
  // the remainder field without knowing the channel count.
  function automatic widths_t trim_widths(widths_t raw, int unsigned num);
    widths_t t = raw;
    for (int unsigned i = 0; i < MAX_OUTPUTS; i++) begin
      if (i + 1 >= num) t[i[2:0]] = '0;
    end
    return t;
  endfunction

  function automatic int unsigned field_w(widths_t widths, int unsigned n,
                                          int unsigned in_width);
    if (widths[n[2:0]] != '0) return widths[n[2:0]];
    return in_width - field_off(widths, n);
  endfunction

  function automatic bit params_ok(widths_t widths, int unsigned num,
                                   int unsigned in_width);
    bit ok = (num >= 1) && (num <= MAX_OUTPUTS) &&
             (in_width >= 2) && (in_width <= 1024);
    if (ok) begin
      for (int unsigned i = 0; i < MAX_OUTPUTS; i++) begin
        if ((i + 1 < num) && (widths[i[2:0]] == '0)) ok = 1'b0;
      end
      if (field_off(widths, num - 1) >= in_width) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/axis_delimiter_if.sv
// Input stream, per-channel output streams and channel mask of axis_delimiter.
interface axis_delimiter_if #(
  parameter int unsigned IN_WIDTH    = 32,
  parameter int unsigned NUM_OUTPUTS = 2
);
  logic [IN_WIDTH-1:0]    s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   s_axis_tlast;
  logic [NUM_OUTPUTS-1:0] chan_en;
  logic [IN_WIDTH-1:0]    m_axis_tdata;
  logic [NUM_OUTPUTS-1:0] m_axis_tvalid;
  logic [NUM_OUTPUTS-1:0] m_axis_tready;
  logic [NUM_OUTPUTS-1:0] m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, chan_en, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, chan_en, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_delimiter_slot.sv
// One output channel: pending flag (IDLE/HELD) with load-over-drain priority.
module axis_delimiter_slot
  import delimiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic ready,
  output logic valid,
  output logic drain
);

  logic [0:0] state_q;

  assign valid = (state_q == SLOT_HELD);
  assign drain = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_IDLE;
    end else if (load) begin
      state_q <= en ? SLOT_HELD : SLOT_IDLE;
    end else if (drain) begin
      state_q <= SLOT_IDLE;
    end
  end

endmodule

// File: rtl/axis_delimiter.sv
// Registered AXI-Stream bit-field delimiter: one held word broadcast to
// NUM_OUTPUTS channels with independent backpressure and masking.
module axis_delimiter
  import delimiter_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 32,
  parameter int unsigned NUM_OUTPUTS = 2,
  parameter int unsigned OUT0_WIDTH  = 16,
  parameter int unsigned OUT1_WIDTH  = 16,
  parameter int unsigned OUT2_WIDTH  = 0,
  parameter int unsigned OUT3_WIDTH  = 0,
  parameter int unsigned OUT4_WIDTH  = 0,
  parameter int unsigned OUT5_WIDTH  = 0,
  parameter int unsigned OUT6_WIDTH  = 0,
  parameter int unsigned OUT7_WIDTH  = 0
) (
  input  logic              clk,
  input  logic              rst,
  axis_delimiter_if.slave   bus,
  output logic [31:0]       frame_count
);

  localparam widths_t WIDTHS = trim_widths({32'(OUT7_WIDTH), 32'(OUT6_WIDTH),
                                            32'(OUT5_WIDTH), 32'(OUT4_WIDTH),
                                            32'(OUT3_WIDTH), 32'(OUT2_WIDTH),
                                            32'(OUT1_WIDTH), 32'(OUT0_WIDTH)},
                                           NUM_OUTPUTS);

  if (!params_ok(WIDTHS, NUM_OUTPUTS, IN_WIDTH)) begin : g_bad_params
    $error("axis_delimiter: illegal IN_WIDTH/NUM_OUTPUTS/field widths");
  end

  logic [IN_WIDTH-1:0]    data_q;
  logic                   last_q;
  logic                   discard_q;
  logic [NUM_OUTPUTS-1:0] pending;
  logic [NUM_OUTPUTS-1:0] drain;
  logic                   s_ready;
  logic                   handshake;
  logic                   word_done;

  assign s_ready   = &(~pending | bus.m_axis_tready);
  assign handshake = bus.s_axis_tvalid & s_ready;
  // The held word completes when every still-pending channel drains together.
  assign word_done = last_q & (|drain) & ((pending & ~drain) == '0);

  for (genvar n = 0; n < NUM_OUTPUTS; n++) begin : g_slot
    if (field_w(WIDTHS, n, IN_WIDTH) == 0) begin : g_bad_field
      $error("axis_delimiter: field %0d has zero width", n);
    end
    axis_delimiter_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (handshake),
      .en    (bus.chan_en[n]),
      .ready (bus.m_axis_tready[n]),
      .valid (pending[n]),
      .drain (drain[n])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      last_q      <= 1'b0;
      discard_q   <= 1'b0;
      frame_count <= '0;
    end else begin
      if (handshake) begin
        data_q <= bus.s_axis_tdata;
        last_q <= bus.s_axis_tlast;
      end
      // A fully masked tlast word is counted one cycle after acceptance.
      discard_q <= handshake & ~(|bus.chan_en) & bus.s_axis_tlast;
      if (word_done | discard_q) frame_count <= frame_count + 32'd1;
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = pending;
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tlast  = {NUM_OUTPUTS{last_q}};

endmodule
